control_sequencer: RTL

//  Hard-wired control unit driving the DataPath control inputs for fetch and execute.

---
 rtl/control_sequencer_if.sv | 36 +++
 rtl/control_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/control_sequencer_if.sv
// Control bundle between the hard-wired sequencer and the DataPath.
// master = sequencer side, slave = DataPath/bench side.
interface control_sequencer_if #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned CNT_W    = 16
);
  logic                run;
  logic [31:0]         ir;
  logic                mem_ready;
  logic [NUM_REGS-1:0] regIn;
  logic [NUM_REGS-1:0] regOut;
  logic                HiIn, LoIn, ZIn, PCIn, MDRIn, YIn, MARIn, IRIn;
  logic                HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut;
  logic                MDRread;
  logic                IncPC;
  logic [4:0]          ALUcode;
  logic                halted;
  logic                fault;
  logic [CNT_W-1:0]    instr_count;

  modport master (
    input  run, ir, mem_ready,
    output regIn, regOut,
    output HiIn, LoIn, ZIn, PCIn, MDRIn, YIn, MARIn, IRIn,
    output HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut,
    output MDRread, IncPC, ALUcode, halted, fault, instr_count
  );

  modport slave (
    output run, ir, mem_ready,
    input  regIn, regOut,
    input  HiIn, LoIn, ZIn, PCIn, MDRIn, YIn, MARIn, IRIn,
    input  HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut,
    input  MDRread, IncPC, ALUcode, halted, fault, instr_count
  );
endinterface

// File: rtl/control_sequencer.sv
// Hard-wired T0..T6 fetch/execute sequencer producing Moore control lines
// for the DataPath: 3-register ALU ops, mul/div into Hi/Lo, and halt.
module control_sequencer #(
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input logic                 clock,
  input logic                 clear,
  control_sequencer_if.master bus
);
  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_HALT = 5'b11010;

  typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, HALT} state_t;

  state_t            state, state_d;
  logic [WAIT_W-1:0] wait_cnt, wait_d;
  logic [4:0]        op_q, op_d;
  logic [3:0]        ra_q, ra_d, rc_q, rc_d;
  logic              fault_q, fault_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              finish;

  logic [4:0] ir_op;
  logic [3:0] ir_ra, ir_rb, ir_rc;
  assign ir_op = bus.ir[31:27];
  assign ir_ra = bus.ir[26:23];
  assign ir_rb = bus.ir[22:19];
  assign ir_rc = bus.ir[18:15];

  // Field values >= NUM_REGS select nothing.
  function automatic logic [NUM_REGS-1:0] reg_sel(input logic [3:0] idx);
    logic [NUM_REGS-1:0] s;
    s = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) s[i] = (32'(idx) == i);
    return s;
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_exec(input logic [4:0] op);
    return (op >= 5'd3 && op <= 5'd11) || is_muldiv(op);
  endfunction

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state    <= IDLE;
      wait_cnt <= '0;
      op_q     <= '0;
      ra_q     <= '0;
      rc_q     <= '0;
      fault_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_d;
      op_q     <= op_d;
      ra_q     <= ra_d;
      rc_q     <= rc_d;
      fault_q  <= fault_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d = state;
    wait_d  = wait_cnt;
    op_d    = op_q;
    ra_d    = ra_q;
    rc_d    = rc_q;
    fault_d = fault_q;
    count_d = count_q;
    finish  = 1'b0;

    bus.regIn   = '0;
    bus.regOut  = '0;
    bus.HiIn    = 1'b0;  bus.LoIn   = 1'b0;  bus.ZIn    = 1'b0;  bus.PCIn   = 1'b0;
    bus.MDRIn   = 1'b0;  bus.YIn    = 1'b0;  bus.MARIn  = 1'b0;  bus.IRIn   = 1'b0;
    bus.HiOut   = 1'b0;  bus.LoOut  = 1'b0;  bus.ZHiOut = 1'b0;  bus.ZLoOut = 1'b0;
    bus.PCOut   = 1'b0;  bus.MDROut = 1'b0;
    bus.MDRread = 1'b0;
    bus.IncPC   = 1'b0;
    bus.ALUcode = '0;
    bus.halted  = 1'b0;

    case (state)
      IDLE: if (bus.run) state_d = T0;
      T0: begin
        bus.PCOut = 1'b1;  bus.MARIn = 1'b1;  bus.IncPC = 1'b1;  bus.ZIn = 1'b1;
        state_d = T1;
      end
      T1: begin
        // PCIn/MDRIn stay high while stalled; Z is unchanged so the reload is harmless.
        bus.ZLoOut = 1'b1;  bus.PCIn = 1'b1;  bus.MDRread = 1'b1;  bus.MDRIn = 1'b1;
        if (bus.mem_ready) begin
          state_d = T2;
          wait_d  = '0;
        end else if (wait_cnt == WAIT_LAST) begin
          state_d = HALT;
          fault_d = 1'b1;
          wait_d  = '0;
        end else begin
          wait_d = wait_cnt + WAIT_W'(1);
        end
      end
      T2: begin
        bus.MDROut = 1'b1;  bus.IRIn = 1'b1;
        state_d = T3;
      end
      T3: begin
        bus.regOut = reg_sel(ir_rb);
        bus.YIn    = 1'b1;
        op_d = ir_op;
        ra_d = ir_ra;
        rc_d = ir_rc;
        if (is_exec(ir_op)) begin
          state_d = T4;
        end else begin
          state_d = HALT;
          fault_d = (ir_op != OP_HALT);
        end
      end
      T4: begin
        bus.regOut  = reg_sel(rc_q);
        bus.ZIn     = 1'b1;
        bus.ALUcode = op_q;
        state_d = T5;
      end
      T5: begin
        bus.ZLoOut = 1'b1;
        if (is_muldiv(op_q)) begin
          bus.LoIn = 1'b1;
          state_d  = T6;
        end else begin
          bus.regIn = reg_sel(ra_q);
          finish    = 1'b1;
        end
      end
      T6: begin
        bus.ZHiOut = 1'b1;  bus.HiIn = 1'b1;
        finish = 1'b1;
      end
      HALT: bus.halted = 1'b1;
      default: state_d = IDLE;
    endcase

    if (finish) begin
      count_d = count_q + CNT_W'(1);
      state_d = bus.run ? T0 : IDLE;
    end
  end

  assign bus.fault       = fault_q;
  assign bus.instr_count = count_q;
endmodule
